muldiv_sequencer: RTL

Multi-cycle unsigned multiply/divide unit that takes MUL and DIV out of the single-cycle ALU path. It accepts one operation at a time over a valid/ready request port and runs one bit per cycle through a shared adder/shifter. It returns a double-width result on a held valid/ready response port. It sits beside the ALU in the execute stage, and the pipeline stalls on `req_ready`/`resp_valid`.

---
 rtl/muldiv_sequencer_pkg.sv | 19 +
 rtl/muldiv_sequencer_datapath.sv | 72 +++++++
 rtl/muldiv_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: opcode codes
// and the sequencer state encoding.
package muldiv_sequencer_pkg;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_MUL = 6'h18;
  localparam logic [5:0] FUNCT_DIV = 6'h1A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_supported(input logic [5:0] funct);
    return (funct == FUNCT_MUL) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Shared shift/add datapath: one bit of shift-add multiply or restoring
// divide per step, with a single WIDTH+1-bit adder/subtractor.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic [WIDTH+1:0] sum;
  logic             q_bit;

  // For DIV the carry out of x + ~d + 1 is set exactly when x >= d.
  always_comb begin
    shifted = {rem_q, lo_q[WIDTH-1]};
    if (is_div) begin
      add_x = shifted;
      add_y = ~{1'b0, opnd_q};
    end else begin
      add_x = {1'b0, rem_q};
      add_y = {1'b0, opnd_q & {WIDTH{lo_q[0]}}};
    end
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div};
    q_bit = sum[WIDTH+1];

    rem_d  = rem_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (load) begin
      rem_d  = '0;
      lo_d   = is_div ? a_in : b_in;
      opnd_d = is_div ? b_in : a_in;
    end else if (step) begin
      if (is_div) begin
        rem_d = q_bit ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], q_bit};
      end else begin
        rem_d = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      rem_q  <= rem_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

  assign hi = rem_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/DIV sequencer: request/response handshakes,
// iteration counter and FSM around the shared datapath.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             is_div_q, is_div_d;
  logic             accept;
  logic             dp_load;
  logic             dp_step;
  logic             dp_is_div;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;

  assign req_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && resp_ready));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_is_div = is_div_q;
    dp_a      = busA;
    dp_b      = busB;

    case (state_q)
      RUN: begin
        dp_step = 1'b1;
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Unsupported codes load zero operands so both results read back as 0.
    if (accept) begin
      dp_load   = 1'b1;
      count_d   = '0;
      is_div_d  = (funct == FUNCT_DIV);
      dp_is_div = (funct == FUNCT_DIV);
      if (is_supported(funct)) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
        dp_a    = '0;
        dp_b    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (dp_load),
    .step   (dp_step),
    .is_div (dp_is_div),
    .a_in   (dp_a),
    .b_in   (dp_b),
    .hi     (result_hi),
    .lo     (result_lo)
  );

endmodule
